// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: FSM state encoding and packed FPU command layout shared by the issue scheduler.
package fpu_sched_pkg;
    localparam int CMD_W = 151;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;
    localparam int OFF_SFPU_OP       = 0;
    localparam int OFF_FPU_RND       = 24;
    localparam int OFF_FPU_PRE       = 27;
    localparam int OFF_FLOAT_CONTROL = 30;
    localparam int OFF_FPU_SEL       = 34;
    localparam int OFF_RS1_EN        = 37;
    localparam int OFF_RS2_EN        = 38;
    localparam int OFF_FS1           = 39;
    localparam int OFF_FS2           = 55;
    localparam int OFF_FS3           = 71;
    localparam int OFF_RS1           = 87;
    localparam int OFF_RS2           = 119;
    // Field order is MSB first, so sfpu_op lands at bit 0 and rs2 at the top.
    typedef struct packed {
        logic [31:0] rs2;
        logic [31:0] rs1;
        logic [15:0] fs3;
        logic [15:0] fs2;
        logic [15:0] fs1;
        logic        rs2_en;
        logic        rs1_en;
        logic [2:0]  fpu_sel;
        logic [3:0]  float_control;
        logic [2:0]  fpu_pre;
        logic [2:0]  fpu_rnd;
        logic [23:0] sfpu_op;
    } fpu_cmd_t;
endpackage

// File: rtl/fpu_rr_arb2.sv
// fpu_rr_arb2: two-way round-robin arbiter; the requester that did not win last time has priority.
module fpu_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    assign o_grant[0] = i_req[0] & (i_last | ~i_req[1]);
    assign o_grant[1] = i_req[1] & (~i_last | ~i_req[0]);
endmodule

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched: issues one command at a time from two requesters onto a shared FPU and returns its result.
// Defining FPU_SCHED_TIMEOUT_EN adds a WAIT-state watchdog that answers with rsp_err after TIMEOUT_CYC cycles.
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter int CMD_W       = fpu_sched_pkg::CMD_W,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*CMD_W-1:0] req_cmd,
    output logic               fpu_valid_execution,
    output logic [CMD_W-1:0]   fpu_cmd,
    input  logic               fpu_complete,
    input  logic               fpu_complete_rd,
    input  logic [15:0]        fpu_result_1,
    input  logic [31:0]        fpu_result_rd,
    input  logic [4:0]         fpu_sflags,
    input  logic               fpu_iv,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_is_int,
    output logic [4:0]         rsp_flags,
    output logic               rsp_iv,
    output logic               rsp_err,
    output logic [CNT_W-1:0]   busy_cnt
);
    state_t             r_state;
    logic               r_last;
    logic               r_valid_ex;
    logic [CMD_W-1:0]   r_fpu_cmd;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_is_int;
    logic [4:0]         r_rsp_flags;
    logic               r_rsp_iv;
    logic [CNT_W-1:0]   r_busy;
    logic [1:0]         w_grant;
    logic               w_gid;
    logic [CMD_W-1:0]   w_cmd;
    logic               w_done;
    logic               w_cap;
    logic               w_timeout;

    fpu_rr_arb2 u_arb (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    assign w_gid     = w_grant[1];
    assign w_cmd     = w_gid ? req_cmd[2*CMD_W-1:CMD_W] : req_cmd[CMD_W-1:0];
    assign w_done    = fpu_complete | fpu_complete_rd;
    assign w_cap     = (r_state == S_ISSUE || r_state == S_WAIT) && w_done;
    assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;

    assign fpu_valid_execution = r_valid_ex;
    assign fpu_cmd             = r_fpu_cmd;
    assign rsp_valid           = r_rsp_valid;
    assign rsp_id              = r_rsp_id;
    assign rsp_result          = r_rsp_result;
    assign rsp_is_int          = r_rsp_is_int;
    assign rsp_flags           = r_rsp_flags;
    assign rsp_iv              = r_rsp_iv;
    assign busy_cnt            = r_busy;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] r_wd;
    logic            r_rsp_err;
    // A completion landing on the final watchdog cycle still wins.
    assign w_timeout = (r_state == S_WAIT) && !w_done && (r_wd == WD_LAST);
    assign rsp_err   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst_l) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_valid_ex   <= 1'b0;
            r_fpu_cmd    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_is_int <= 1'b0;
            r_rsp_flags  <= '0;
            r_rsp_iv     <= 1'b0;
            r_busy       <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
            r_wd         <= '0;
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_valid_ex <= 1'b0;
            case (r_state)
                S_IDLE: if (|req_valid) begin
                    r_fpu_cmd  <= w_cmd;
                    r_rsp_id   <= w_gid;
                    r_last     <= w_gid;
                    r_valid_ex <= 1'b1;
                    r_state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_busy  <= '0;
                    r_state <= w_done ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    r_busy <= (&r_busy) ? r_busy : r_busy + 1'b1;
                    if (w_done || w_timeout) r_state <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
            // Integer completion takes priority when both completions fire together.
            if (w_cap) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= fpu_complete_rd ? fpu_result_rd : {16'h0, fpu_result_1};
                r_rsp_is_int <= fpu_complete_rd;
                r_rsp_flags  <= fpu_sflags;
                r_rsp_iv     <= fpu_iv;
            end
`ifdef FPU_SCHED_TIMEOUT_EN
            r_wd <= (r_state == S_WAIT) ? r_wd + 1'b1 : '0;
            if (w_cap) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_err    <= 1'b1;
                r_rsp_result <= '0;
                r_rsp_is_int <= 1'b0;
                r_rsp_flags  <= '0;
                r_rsp_iv     <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched: directed scoreboard bench for fpu_issue_sched.
// Exercises the FPU_SCHED_TIMEOUT_EN path when that macro is defined, saturation of busy_cnt otherwise.
module tb_fpu_issue_sched;
    import fpu_sched_pkg::*;
    localparam int CW = fpu_sched_pkg::CMD_W;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        is_int;
        logic [4:0]  flags;
        logic        iv;
        logic        err;
        logic [7:0]  busy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_l = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*CW-1:0] req_cmd = '0;
    logic            fpu_valid_execution;
    logic [CW-1:0]   fpu_cmd;
    logic            fpu_complete = 1'b0;
    logic            fpu_complete_rd = 1'b0;
    logic [15:0]     fpu_result_1 = '0;
    logic [31:0]     fpu_result_rd = '0;
    logic [4:0]      fpu_sflags = '0;
    logic            fpu_iv = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_is_int;
    logic [4:0]      rsp_flags;
    logic            rsp_iv;
    logic            rsp_err;
    logic [7:0]      busy_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic tb_last = 1'b1;

    always #5 clk = ~clk;

    fpu_issue_sched dut (
        .clk                 (clk),
        .rst_l               (rst_l),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_cmd             (req_cmd),
        .fpu_valid_execution (fpu_valid_execution),
        .fpu_cmd             (fpu_cmd),
        .fpu_complete        (fpu_complete),
        .fpu_complete_rd     (fpu_complete_rd),
        .fpu_result_1        (fpu_result_1),
        .fpu_result_rd       (fpu_result_rd),
        .fpu_sflags          (fpu_sflags),
        .fpu_iv              (fpu_iv),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_result          (rsp_result),
        .rsp_is_int          (rsp_is_int),
        .rsp_flags           (rsp_flags),
        .rsp_iv              (rsp_iv),
        .rsp_err             (rsp_err),
        .busy_cnt            (busy_cnt)
    );

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] mk_cmd(input logic [23:0] op);
        fpu_cmd_t c;
        c         = '0;
        c.sfpu_op = op;
        c.fpu_rnd = 3'($urandom_range(0, 7));
        c.fs1     = 16'($urandom);
        c.rs1     = $urandom;
        c.rs2     = $urandom;
        c.rs1_en  = 1'b1;
        return c;
    endfunction

    // One full transaction: accept, issue, completion k cycles after issue, optional stall, handshake.
    task automatic run_op(input logic [1:0] vld, input int k, input logic c1, input logic crd,
                          input logic [15:0] r1, input logic [31:0] rrd, input logic [4:0] fl,
                          input logic iv, input int stall, input logic [23:0] op);
        exp_t          e;
        exp_t          got;
        logic          g;
        int            pulses;
        int            early;
        logic [CW-1:0] c0;
        logic [CW-1:0] cc1;
        logic [CW-1:0] ec;
        g       = vld[!tb_last] ? !tb_last : tb_last;
        tb_last = g;
        c0      = mk_cmd(op);
        cc1     = mk_cmd(op + 24'd1);
        ec      = g ? cc1 : c0;
        e.err    = !(c1 | crd);
        e.id     = g;
        e.result = e.err ? 32'h0 : (crd ? rrd : {16'h0, r1});
        e.is_int = crd;
        e.flags  = e.err ? 5'h0 : fl;
        e.iv     = e.err ? 1'b0 : iv;
        e.busy   = (k > 255) ? 8'hFF : 8'(k);
        sb.push_back(e);
        req_cmd   = {cc1, c0};
        req_valid = vld;
        #1;
        chk("req_ready", CW'(req_ready), g ? CW'(2'b10) : CW'(2'b01));
        tick();
        pulses = int'(fpu_valid_execution);
        early  = 0;
        chk("fpu_cmd", fpu_cmd, ec);
        chk("ready_in_issue", CW'(req_ready), '0);
        for (int i = 0; i < k; i++) begin
            tick();
            pulses += int'(fpu_valid_execution);
            early  += int'(rsp_valid);
        end
        fpu_complete    = c1;
        fpu_complete_rd = crd;
        fpu_result_1    = r1;
        fpu_result_rd   = rrd;
        fpu_sflags      = fl;
        fpu_iv          = iv;
        tick();
        fpu_complete    = 1'b0;
        fpu_complete_rd = 1'b0;
        fpu_result_1    = 16'($urandom);
        fpu_result_rd   = $urandom;
        fpu_sflags      = 5'($urandom);
        fpu_iv          = 1'b0;
        chk("rsp_valid", CW'(rsp_valid), CW'(1));
        chk("issue_pulses", CW'(pulses), CW'(1));
        chk("early_rsp", CW'(early), '0);
        if (rsp_valid) begin
            got = sb.pop_front();
            chk("rsp_id", CW'(rsp_id), CW'(got.id));
            chk("rsp_result", CW'(rsp_result), CW'(got.result));
            chk("rsp_is_int", CW'(rsp_is_int), CW'(got.is_int));
            chk("rsp_flags", CW'(rsp_flags), CW'(got.flags));
            chk("rsp_iv", CW'(rsp_iv), CW'(got.iv));
            chk("rsp_err", CW'(rsp_err), CW'(got.err));
            chk("busy_cnt", CW'(busy_cnt), CW'(got.busy));
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("stall_valid", CW'(rsp_valid), CW'(1));
                chk("stall_result", CW'(rsp_result), CW'(got.result));
                chk("stall_id", CW'(rsp_id), CW'(got.id));
                chk("stall_cmd", fpu_cmd, ec);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", CW'(rsp_valid), '0);
        chk("cmd_hold", fpu_cmd, ec);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req_ready", CW'(req_ready), '0);
        chk("rst_pulse", CW'(fpu_valid_execution), '0);
        chk("rst_cmd", fpu_cmd, '0);
        chk("rst_rsp_valid", CW'(rsp_valid), '0);
        chk("rst_rsp_result", CW'(rsp_result), '0);
        chk("rst_busy", CW'(busy_cnt), '0);
        rst_l = 1'b0;
        tick();
        // contention: grants alternate starting with requester 0
        run_op(2'b11, 0, 1'b1, 1'b0, 16'h1111, 32'h0, 5'b00001, 1'b0, 0, 24'h000010);
        run_op(2'b11, 1, 1'b1, 1'b0, 16'h2222, 32'h0, 5'b00010, 1'b0, 0, 24'h000020);
        run_op(2'b11, 2, 1'b0, 1'b1, 16'h0, 32'h1234_5678, 5'b00100, 1'b0, 1, 24'h000030);
        run_op(2'b11, 0, 1'b1, 1'b0, 16'h4444, 32'h0, 5'b01000, 1'b1, 0, 24'h000040);
        // single request, completion in ISSUE
        run_op(2'b01, 0, 1'b1, 1'b0, 16'h3F80, 32'h0, 5'b00000, 1'b0, 0, 24'h000001);
        // multi-cycle op with a stalled response
        run_op(2'b10, 10, 1'b1, 1'b0, 16'hC000, 32'h0, 5'b00011, 1'b0, 3, 24'h000050);
        // both completions high: integer result wins
        run_op(2'b01, 1, 1'b1, 1'b1, 16'h5555, 32'hFFFF_FFFE, 5'b10000, 1'b1, 0, 24'h000060);
        // reset in the middle of WAIT
        req_cmd   = {mk_cmd(24'h71), mk_cmd(24'h70)};
        req_valid = 2'b11;
        tick();
        tick();
        tick();
        tick();
        req_valid = 2'b00;
        rst_l     = 1'b1;
        tb_last   = 1'b1;
        tick();
        rst_l = 1'b0;
        chk("mid_rst_pulse", CW'(fpu_valid_execution), '0);
        chk("mid_rst_cmd", fpu_cmd, '0);
        chk("mid_rst_rsp_valid", CW'(rsp_valid), '0);
        chk("mid_rst_busy", CW'(busy_cnt), '0);
        chk("mid_rst_result", CW'(rsp_result), '0);
        fpu_complete = 1'b1;
        fpu_result_1 = 16'hBEEF;
        tick();
        fpu_complete = 1'b0;
        chk("late_complete", CW'(rsp_valid), '0);
        tick();
        chk("late_complete_2", CW'(rsp_valid), '0);
        run_op(2'b11, 3, 1'b1, 1'b0, 16'h0ABC, 32'h0, 5'b00101, 1'b0, 0, 24'h000080);
`ifdef FPU_SCHED_TIMEOUT_EN
        run_op(2'b01, 64, 1'b0, 1'b0, 16'h0, 32'h0, 5'b00000, 1'b0, 0, 24'h000090);
        run_op(2'b10, 2, 1'b1, 1'b0, 16'h7777, 32'h0, 5'b00001, 1'b0, 0, 24'h0000A0);
`else
        run_op(2'b10, 260, 1'b1, 1'b0, 16'h6666, 32'h0, 5'b11111, 1'b1, 0, 24'h000090);
`endif
        chk("scoreboard_empty", CW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
